seg_scan_decoder: RTL and testbench

//  Receive-side counterpart of the multiplexed 4-digit seven-segment driver.

---
 rtl/seg_scan_decoder.sv | 185 ++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 4-digit seven-segment scan. Rebuilds the displayed
// hex digits/dps from SEGMENT/AN and publishes them as one atomic frame per full scan.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  SEGMENT,
    input  logic [3:0]  AN,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic [3:0]  blank,
    output logic [3:0]  invalid,
    output logic        frame_valid,
    output logic        stale
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] STB  = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam bit ONE = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {IDLE, DWELL, HELD} state_t;
    typedef struct packed {
        logic [3:0] val;
        logic       dp;
        logic       blank;
        logic       inv;
    } dig_t;

    function automatic logic onehot_low(input logic [3:0] a);
        return (a == 4'hE) || (a == 4'hD) || (a == 4'hB) || (a == 4'h7);
    endfunction

    function automatic logic [1:0] an_idx(input logic [3:0] a);
        case (a)
            4'hE:    return 2'd0;
            4'hD:    return 2'd1;
            4'hB:    return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic dig_t decode(input logic [7:0] seg);
        logic [6:0] s;
        dig_t       d;
        s    = ~seg[6:0];
        d    = '0;
        d.dp = ~seg[7];
        case (s)
            7'h00:   d.blank = 1'b1;
            7'h3F:   d.val = 4'h0;
            7'h06:   d.val = 4'h1;
            7'h5B:   d.val = 4'h2;
            7'h4F:   d.val = 4'h3;
            7'h66:   d.val = 4'h4;
            7'h6D:   d.val = 4'h5;
            7'h7D:   d.val = 4'h6;
            7'h07:   d.val = 4'h7;
            7'h7F:   d.val = 4'h8;
            7'h6F:   d.val = 4'h9;
            7'h77:   d.val = 4'hA;
            7'h7C:   d.val = 4'hB;
            7'h39:   d.val = 4'hC;
            7'h5E:   d.val = 4'hD;
            7'h79:   d.val = 4'hE;
            7'h71:   d.val = 4'hF;
            default: d.inv = 1'b1;
        endcase
        return d;
    endfunction

    logic [7:0]    seg_s1, seg_s2, seg_q;
    logic [3:0]    an_s1, an_s2, an_q;
    state_t        state;
    logic [CW-1:0] cnt, cnt_inc;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [3:0]    seen, seen_nxt;
    dig_t [3:0]    shadow;
    logic          same, cap;
    logic [1:0]    cap_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            an_s1  <= '0;
            an_s2  <= '0;
        end else begin
            seg_s1 <= SEGMENT;
            seg_s2 <= seg_s1;
            an_s1  <= AN;
            an_s2  <= an_s1;
        end
    end

    // A fresh sample (cnt=1) is already a capture when only one stable cycle is required.
    always_comb begin
        same    = (an_s2 == an_q) && (seg_s2 == seg_q);
        cnt_inc = cnt + CW'(1);
        cap_idx = an_idx(an_s2);
        cap     = 1'b0;
        case (state)
            IDLE:    cap = ONE && onehot_low(an_s2);
            DWELL:   cap = same ? (cnt_inc >= STB) : (ONE && onehot_low(an_s2));
            HELD:    cap = ONE && (an_s2 != an_q) && onehot_low(an_s2);
            default: cap = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            an_q  <= '0;
            seg_q <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                DWELL: begin
                    if (same) begin
                        cnt <= cnt_inc;
                        if (cap) state <= HELD;
                    end else begin
                        an_q  <= an_s2;
                        seg_q <= seg_s2;
                        cnt   <= CW'(1);
                        state <= !onehot_low(an_s2) ? IDLE : (ONE ? HELD : DWELL);
                    end
                end
                HELD: begin
                    if (an_s2 != an_q) begin
                        an_q  <= an_s2;
                        seg_q <= seg_s2;
                        cnt   <= CW'(1);
                        state <= !onehot_low(an_s2) ? IDLE : (ONE ? HELD : DWELL);
                    end
                end
                default: begin
                    an_q  <= an_s2;
                    seg_q <= seg_s2;
                    cnt   <= CW'(1);
                    if (onehot_low(an_s2)) state <= ONE ? HELD : DWELL;
                end
            endcase
        end
    end

    // A capture in the timeout cycle wins: counter restarts and seen keeps its bits.
    always_comb begin
        tcnt_nxt = cap ? '0 : ((tcnt == TMAX) ? tcnt : tcnt + TW'(1));
        seen_nxt = seen;
        if (seen == 4'hF) seen_nxt = '0;
        if (tcnt_nxt == TMAX) seen_nxt = '0;
        if (cap) seen_nxt[cap_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt        <= '0;
            stale       <= 1'b0;
            seen        <= '0;
            shadow      <= '0;
            frame_valid <= 1'b0;
            digits      <= '0;
            dps         <= '0;
            blank       <= '0;
            invalid     <= '0;
        end else begin
            tcnt        <= tcnt_nxt;
            stale       <= (tcnt_nxt == TMAX);
            seen        <= seen_nxt;
            frame_valid <= (seen == 4'hF);
            if (cap) shadow[cap_idx] <= decode(seg_s2);
            if (seen == 4'hF) begin
                for (int i = 0; i < 4; i++) begin
                    digits[4*i +: 4] <= shadow[i].val;
                    dps[i]           <= shadow[i].dp;
                    blank[i]         <= shadow[i].blank;
                    invalid[i]       <= shadow[i].inv;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a per-cycle behavioural model pushes expected
// frames; a monitor pops one per frame_valid pulse.
module tb_seg_scan_decoder;
    localparam int STB = 4;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  SEGMENT = 8'hFF;
    logic [3:0]  AN = 4'hF;
    logic [15:0] digits;
    logic [3:0]  dps, blank, invalid;
    logic        frame_valid, stale;

    seg_scan_decoder #(.STABLE_CYCLES(STB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .SEGMENT(SEGMENT), .AN(AN),
        .digits(digits), .dps(dps), .blank(blank), .invalid(invalid),
        .frame_valid(frame_valid), .stale(stale)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [27:0] expq[$];
    logic [27:0] m_last = '0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0] sel_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [3:0] bad_tab [4] = '{4'hC, 4'hF, 4'h0, 4'h3};

    // Reference model state: current run of identical inputs, per-digit slots, timeout.
    logic [3:0] m_prev_an = '0;
    logic [7:0] m_prev_seg = '0;
    int         m_run = 0;
    bit         m_locked = 0;
    logic [3:0] m_seen = '0;
    logic [6:0] m_slot [4];
    int         m_tcount = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int digit_of(input logic [3:0] an);
        for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) return i;
        return -1;
    endfunction

    // Returns {val[3:0], dp, blank, inv}
    function automatic logic [6:0] ref_decode(input logic [7:0] seg);
        logic [6:0] s;
        s = ~seg[6:0];
        if (s == 7'h00) return {4'h0, ~seg[7], 1'b1, 1'b0};
        for (int v = 0; v < 16; v++) if (glyph[v] == s) return {4'(v), ~seg[7], 1'b0, 1'b0};
        return {4'h0, ~seg[7], 1'b0, 1'b1};
    endfunction

    task automatic model_reset();
        m_prev_an = '0; m_prev_seg = '0; m_run = 0; m_locked = 0;
        m_seen = '0; m_tcount = 0;
    endtask

    task automatic model_cycle(input logic [3:0] an, input logic [7:0] seg);
        int d;
        logic [27:0] f;
        if (an != m_prev_an) m_locked = 0;
        if (an == m_prev_an && seg == m_prev_seg) m_run++; else m_run = 1;
        m_prev_an = an; m_prev_seg = seg;
        d = digit_of(an);
        if (d >= 0 && !m_locked && m_run == STB) begin
            m_locked  = 1;
            m_slot[d] = ref_decode(seg);
            m_seen[d] = 1'b1;
            m_tcount  = 0;
        end else begin
            if (m_tcount < TMO) m_tcount++;
            if (m_tcount == TMO) m_seen = '0;
        end
        if (m_seen == 4'hF) begin
            f = '0;
            for (int i = 0; i < 4; i++) begin
                f[12 + 4*i +: 4] = m_slot[i][6:3];
                f[8 + i]         = m_slot[i][2];
                f[4 + i]         = m_slot[i][1];
                f[i]             = m_slot[i][0];
            end
            expq.push_back(f);
            m_last = f;
            m_seen = '0;
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            AN = an; SEGMENT = seg;
            model_cycle(an, seg);
        end
    endtask

    task automatic scan(input logic [7:0] s0, s1, s2, s3, input int n);
        drive(4'hE, s0, n); drive(4'hD, s1, n); drive(4'hB, s2, n); drive(4'h7, s3, n);
    endtask

    function automatic logic [7:0] rand_seg();
        int k;
        k = $urandom_range(0, 7);
        if (k < 4) return {1'($urandom_range(0, 1)), ~glyph[$urandom_range(0, 15)]};
        if (k < 6) return ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h7F;
        return 8'($urandom);
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'h0);
        check({tag, "_dps"}, 32'(dps), 32'h0);
        check({tag, "_blank"}, 32'(blank), 32'h0);
        check({tag, "_invalid"}, 32'(invalid), 32'h0);
        check({tag, "_frame_valid"}, 32'(frame_valid), 32'h0);
        check({tag, "_stale"}, 32'(stale), 32'h0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_valid === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame: got %h expected no frame at %0t",
                         {digits, dps, blank, invalid}, $time);
            end else begin
                check("frame", 32'({digits, dps, blank, invalid}), 32'(expq.pop_front()));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        model_reset();

        // Documented scan pattern, then the same AN set with dp/blank/invalid glyphs.
        scan(8'h92, 8'h88, 8'hA4, 8'hF9, 8);
        scan(8'hFF, 8'h40, 8'h0C, 8'hC0, 8);
        scan(8'h7F, 8'hF9, 8'h24, 8'h30, 8);
        scan(8'hAA, 8'h86, 8'h8E, 8'hA1, 8);

        // Dwell one short of STABLE, then change: no capture until a full dwell.
        drive(4'hE, 8'hC0, STB - 1);
        drive(4'hE, 8'hF9, STB - 1);
        drive(4'hD, 8'hA4, STB);
        drive(4'hE, 8'h99, STB);
        drive(4'hB, 8'hB0, STB);
        drive(4'hD, 8'h92, STB - 1);
        drive(4'h7, 8'h82, STB + 2);

        // Non-one-hot anodes leave the partial frame intact.
        drive(4'hE, 8'hF8, 8); drive(4'hD, 8'h80, 8);
        drive(4'hC, 8'h90, 100); drive(4'hF, 8'h90, 20);
        drive(4'hB, 8'h88, 8); drive(4'h7, 8'h83, 8);

        // Held digit: segment changes on the same anode are ignored.
        drive(4'hE, 8'hC6, 6); drive(4'hE, 8'hA1, 6);
        drive(4'hD, 8'h86, 6); drive(4'hB, 8'h8E, 6); drive(4'h7, 8'hC0, 6);

        for (int r = 0; r < 400; r++) begin
            logic [3:0] an;
            if ($urandom_range(0, 7) == 0) an = bad_tab[$urandom_range(0, 3)];
            else an = sel_tab[$urandom_range(0, 3)];
            drive(an, rand_seg(), $urandom_range(1, 8));
        end

        // Timeout: stale rises only after TMO idle cycles, outputs hold the last frame.
        scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 8);
        drive(4'hF, 8'hFF, TMO - 50);
        check("stale_before_timeout", 32'(stale), 32'h0);
        drive(4'hF, 8'hFF, 100);
        check("stale_after_timeout", 32'(stale), 32'h1);
        check("hold_after_timeout", 32'({digits, dps, blank, invalid}), 32'(m_last));
        drive(4'hE, 8'h92, 8);
        check("stale_cleared", 32'(stale), 32'h0);
        drive(4'hD, 8'h82, 8); drive(4'hB, 8'hF8, 8); drive(4'h7, 8'h80, 8);

        // Mid-operation reset after three digits discards the partial frame.
        drive(4'hE, 8'hC0, 8); drive(4'hD, 8'hF9, 8); drive(4'hB, 8'hA4, 8);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(4'h7, 8'hB0, 8);
        drive(4'hF, 8'hFF, 10);
        scan(8'h99, 8'h92, 8'h82, 8'hF8, 8);

        for (int i = 0; i < 50 && expq.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        check("drain", 32'(expq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
